// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the in-order pipeline (master) and pipe_hazard_ctrl (slave).
// The master drives ID-stage operand info and redirect events. It receives interlock, flush and bypass controls.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned RBITS = 5,
    parameter int unsigned SELW  = 3
);
    logic             id_valid;
    logic [RBITS-1:0] id_rs1;
    logic [RBITS-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RBITS-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_multi;
    logic             mc_done;
    logic             br_taken;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [DEPTH-1:0] flush_mask;
    logic [SELW-1:0]  fwd_a;
    logic [SELW-1:0]  fwd_b;
    logic [31:0]      stall_cnt;
    logic [31:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_multi, mc_done, br_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, flush_mask,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_regwrite, id_memread, id_multi, mc_done, br_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, flush_mask,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the in-order RV32 pipeline: shadow scoreboard, bypass select, load-use
// and multi-cycle interlocks, branch flush. Define HAZ_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned RBITS    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned SELW     = 3
) (
    input  logic              CLK,
    input  logic              RSTa,
    pipe_hazard_ctrl_if.slave hz_if
);

    localparam int unsigned      BR_MASK_INT = (1 << (BR_STAGE - 1)) - 1;
    localparam logic [DEPTH-1:0] BR_MASK     = DEPTH'(BR_MASK_INT);

    typedef enum logic {StIdle, StMcBusy} state_e;

    typedef struct packed {
        logic            lu;
        logic [SELW-1:0] sel;
    } byp_t;

    // Youngest matching stage wins; a load still inside LOAD_LAT cannot be a source.
    function automatic byp_t lookup(
        input logic             used,
        input logic [RBITS-1:0] rs,
        input logic [DEPTH:1]   vld,
        input logic [DEPTH:1]   ld,
        input logic [RBITS-1:0] rd [1:DEPTH]
    );
        byp_t res;
        logic hit;
        res = '0;
        hit = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit && used && (rs != '0) && vld[k] && (rd[k] == rs)) begin
                hit = 1'b1;
                if (ld[k] && (k <= LOAD_LAT)) res.lu = 1'b1;
                else                          res.sel = SELW'(k);
            end
        end
        return res;
    endfunction

    logic [DEPTH:1]   r_vld;
    logic [DEPTH:1]   r_ld;
    logic [RBITS-1:0] r_rd [1:DEPTH];
    state_e           r_state;

    logic [DEPTH:1]   w_vld_nxt;
    logic [DEPTH:1]   w_ld_nxt;
    logic [RBITS-1:0] w_rd_nxt [1:DEPTH];
    state_e           w_state_nxt;

    byp_t             w_byp_a;
    byp_t             w_byp_b;
    logic             w_load_use;
    logic             w_busy_hold;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_idex_bubble;
    logic             w_ifid_flush;
    logic [DEPTH-1:0] w_flush_mask;

    assign w_byp_a    = lookup(hz_if.id_rs1_used, hz_if.id_rs1, r_vld, r_ld, r_rd);
    assign w_byp_b    = lookup(hz_if.id_rs2_used, hz_if.id_rs2, r_vld, r_ld, r_rd);
    assign w_load_use = hz_if.id_valid & (w_byp_a.lu | w_byp_b.lu);
    // The mc_done cycle releases the interlock so the MC op leaves EX on that edge.
    assign w_busy_hold = (r_state == StMcBusy) & ~hz_if.mc_done;

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        w_flush_mask  = '0;
        if (hz_if.br_taken) begin
            w_idex_bubble = 1'b1;
            w_ifid_flush  = 1'b1;
            w_flush_mask  = BR_MASK;
        end else if (w_busy_hold) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        w_vld_nxt    = r_vld;
        w_ld_nxt     = r_ld;
        w_rd_nxt     = r_rd;
        w_state_nxt  = r_state;
        w_vld_nxt[1] = hz_if.id_valid & hz_if.id_regwrite & (hz_if.id_rd != '0) & ~w_idex_bubble;
        w_rd_nxt[1]  = hz_if.id_rd;
        w_ld_nxt[1]  = hz_if.id_memread;
        for (int k = 2; k <= DEPTH; k++) begin
            w_vld_nxt[k] = r_vld[k-1];
            w_rd_nxt[k]  = r_rd[k-1];
            w_ld_nxt[k]  = r_ld[k-1];
        end
        if (hz_if.br_taken) begin
            // Everything younger than the branch is killed on its way down the pipe.
            for (int k = 1; k <= BR_STAGE; k++) w_vld_nxt[k] = 1'b0;
            if (BR_STAGE > 1) w_state_nxt = StIdle;
        end else if (w_busy_hold) begin
            w_vld_nxt[1] = r_vld[1];
            w_rd_nxt[1]  = r_rd[1];
            w_ld_nxt[1]  = r_ld[1];
            w_vld_nxt[2] = 1'b0;
        end else if (hz_if.id_valid && hz_if.id_multi && !w_idex_bubble) begin
            w_state_nxt = StMcBusy;
        end else begin
            w_state_nxt = StIdle;
        end
    end

    always_ff @(negedge CLK or posedge RSTa) begin
        if (RSTa) begin
            r_vld   <= '0;
            r_ld    <= '0;
            r_rd    <= '{default: '0};
            r_state <= StIdle;
        end else begin
            r_vld   <= w_vld_nxt;
            r_ld    <= w_ld_nxt;
            r_rd    <= w_rd_nxt;
            r_state <= w_state_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(negedge CLK or posedge RSTa) begin
        if (RSTa) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && !hz_if.br_taken) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (hz_if.br_taken)                 r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign hz_if.stall_cnt = r_stall_cnt;
    assign hz_if.flush_cnt = r_flush_cnt;
`else
    assign hz_if.stall_cnt = '0;
    assign hz_if.flush_cnt = '0;
`endif

    assign hz_if.pc_write    = w_pc_write;
    assign hz_if.ifid_write  = w_ifid_write;
    assign hz_if.idex_bubble = w_idex_bubble;
    assign hz_if.ifid_flush  = w_ifid_flush;
    assign hz_if.flush_mask  = w_flush_mask;
    assign hz_if.fwd_a       = w_byp_a.sel;
    assign hz_if.fwd_b       = w_byp_b.sel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, reset-during-MC sequence, and random
// stimulus checked against a queue-of-instructions reference model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned DEPTH    = 3;
    localparam int unsigned RBITS    = 5;
    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned BR_STAGE = 2;
    localparam int unsigned SELW     = 3;
`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic vld; logic [RBITS-1:0] rs1; logic [RBITS-1:0] rs2; logic u1; logic u2;
        logic [RBITS-1:0] rd; logic rw; logic mr; logic mul; logic done; logic br;
    } in_t;
    typedef struct packed {
        logic pc; logic ifid; logic bub; logic fl; logic [DEPTH-1:0] mask;
        logic [SELW-1:0] fa; logic [SELW-1:0] fb;
    } exp_t;
    typedef struct { in_t in; exp_t ex; } vec_t;
    typedef struct { bit v; int rd; bit ld; } ent_t;

    logic CLK  = 1'b1;
    logic RSTa = 1'b1;
    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.DEPTH(DEPTH), .RBITS(RBITS), .SELW(SELW)) hz ();

    pipe_hazard_ctrl #(
        .DEPTH(DEPTH), .RBITS(RBITS), .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE), .SELW(SELW)
    ) dut (
        .CLK(CLK),
        .RSTa(RSTa),
        .hz_if(hz)
    );

    int          n_chk = 0;
    int          n_err = 0;
    ent_t        sb[$];      // sb[0] is the instruction in EX
    bit          m_busy;
    int unsigned m_stall;
    int unsigned m_flush;
    vec_t        tbl[$];

    function automatic in_t ins(bit vld, int rs1, int rs2, bit u1, bit u2, int rd, bit rw,
                                bit mr, bit mul, bit done, bit br);
        in_t v;
        v.vld = vld; v.rs1 = RBITS'(rs1); v.rs2 = RBITS'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = RBITS'(rd); v.rw = rw; v.mr = mr; v.mul = mul; v.done = done; v.br = br;
        return v;
    endfunction

    function automatic exp_t ex(bit pc, bit ifid, bit bub, bit fl, int mask, int fa, int fb);
        exp_t e;
        e.pc = pc; e.ifid = ifid; e.bub = bub; e.fl = fl; e.mask = DEPTH'(mask);
        e.fa = SELW'(fa); e.fb = SELW'(fb);
        return e;
    endfunction

    task automatic addv(input in_t v, input exp_t e);
        vec_t t;
        t.in = v;
        t.ex = e;
        tbl.push_back(t);
    endtask

    function automatic void model_reset();
        ent_t z;
        z.v = 1'b0; z.rd = 0; z.ld = 1'b0;
        sb.delete();
        for (int i = 0; i < int'(DEPTH); i++) sb.push_back(z);
        m_busy  = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Stage number of the youngest writer of rs, 0 if none, -1 if it is a load not yet usable.
    function automatic int src(logic used, logic [RBITS-1:0] rs);
        if (!used || rs == 0) return 0;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].v && sb[i].rd == int'(rs))
                return (sb[i].ld && (i + 1) <= int'(LOAD_LAT)) ? -1 : i + 1;
        return 0;
    endfunction

    function automatic exp_t model_out(in_t v);
        exp_t e;
        int   sa;
        int   sbb;
        sa  = src(v.u1, v.rs1);
        sbb = src(v.u2, v.rs2);
        e = ex(1, 1, 0, 0, 0, (sa > 0) ? sa : 0, (sbb > 0) ? sbb : 0);
        if (v.br) begin
            e.bub = 1'b1;
            e.fl  = 1'b1;
            for (int b = 0; b <= int'(BR_STAGE) - 2; b++) e.mask[b] = 1'b1;
        end else if (m_busy && !v.done) begin
            e.pc = 1'b0; e.ifid = 1'b0;
        end else if (v.vld && (sa < 0 || sbb < 0)) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
        end
        return e;
    endfunction

    function automatic void model_update(in_t v, exp_t e);
        ent_t nw;
        ent_t held;
        nw.v  = v.vld && v.rw && (v.rd != 0) && !e.bub;
        nw.rd = int'(v.rd);
        nw.ld = v.mr;
        if (!e.pc && !v.br) m_stall++;
        if (v.br) m_flush++;
        if (v.br) begin
            nw.v = 1'b0;
            sb.push_front(nw);
            void'(sb.pop_back());
            for (int i = 0; i < int'(BR_STAGE); i++) sb[i].v = 1'b0;
            if (BR_STAGE > 1) m_busy = 1'b0;
        end else if (m_busy && !v.done) begin
            held = sb[0];
            sb[0].v = 1'b0;
            sb.push_front(held);
            void'(sb.pop_back());
        end else begin
            sb.push_front(nw);
            void'(sb.pop_back());
            m_busy = v.vld && v.mul && !e.bub;
        end
    endfunction

    task automatic drive(input in_t v);
        hz.id_valid    = v.vld;
        hz.id_rs1      = v.rs1;
        hz.id_rs2      = v.rs2;
        hz.id_rs1_used = v.u1;
        hz.id_rs2_used = v.u2;
        hz.id_rd       = v.rd;
        hz.id_regwrite = v.rw;
        hz.id_memread  = v.mr;
        hz.id_multi    = v.mul;
        hz.mc_done     = v.done;
        hz.br_taken    = v.br;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " pc_write"},    32'(hz.pc_write),    32'(e.pc));
        chk({tag, " ifid_write"},  32'(hz.ifid_write),  32'(e.ifid));
        chk({tag, " idex_bubble"}, 32'(hz.idex_bubble), 32'(e.bub));
        chk({tag, " ifid_flush"},  32'(hz.ifid_flush),  32'(e.fl));
        chk({tag, " flush_mask"},  32'(hz.flush_mask),  32'(e.mask));
        chk({tag, " fwd_a"},       32'(hz.fwd_a),       32'(e.fa));
        chk({tag, " fwd_b"},       32'(hz.fwd_b),       32'(e.fb));
    endtask

    // Drive after the falling (active) edge, sample on the rising edge.
    task automatic step(input in_t v, input exp_t e_tab, input bit use_tab, input string tag);
        exp_t e_mod;
        drive(v);
        @(posedge CLK);
        e_mod = model_out(v);
        chk_all(tag, use_tab ? e_tab : e_mod);
        @(negedge CLK);
        #1;
        model_update(v, e_mod);
    endtask

    initial begin
        in_t  v;
        exp_t e0;

        // lw x5 / add x6,x5,x1: one load-use stall, then bypass from stage 2
        addv(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 0, 0));
        addv(ins(1, 2, 0, 1, 0, 5, 1, 1, 0, 0, 0),  ex(1, 1, 0, 0, 0, 0, 0));
        addv(ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0),  ex(0, 0, 1, 0, 0, 0, 0));
        addv(ins(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 2, 0));
        // add x5 / sub x7,x5,x5 back to back; x0 destination never bypasses
        addv(ins(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 0, 0));
        addv(ins(1, 5, 5, 1, 1, 7, 1, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 1, 1));
        addv(ins(1, 7, 6, 1, 1, 0, 1, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 1, 3));
        addv(ins(1, 0, 5, 1, 1, 9, 0, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 0, 3));
        addv(ins(1, 7, 7, 0, 1, 0, 0, 0, 0, 0, 0),  ex(1, 1, 0, 0, 0, 0, 3));
        // div x8, eight busy cycles, mc_done releases; mc_done in idle ignored
        addv(ins(1, 3, 4, 1, 1, 8, 1, 0, 1, 0, 0),  ex(1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            addv(ins(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 1, 0));
        addv(ins(1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 0),  ex(1, 1, 0, 0, 0, 1, 0));
        addv(ins(1, 8, 9, 1, 1, 0, 0, 0, 0, 1, 0),  ex(1, 1, 0, 0, 0, 2, 1));
        // branch while load-use pending: flush wins and the load entry is dropped
        addv(ins(1, 2, 0, 0, 0, 10, 1, 1, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 0));
        addv(ins(1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 1), ex(1, 1, 1, 1, 1, 0, 0));
        addv(ins(1, 10, 0, 1, 1, 11, 1, 0, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 0));
        // branch during MC busy returns the FSM to idle
        addv(ins(1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0),  ex(1, 1, 0, 0, 0, 0, 0));
        addv(ins(1, 11, 12, 1, 1, 13, 1, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 2, 1));
        addv(ins(1, 11, 12, 1, 1, 13, 1, 0, 0, 0, 1), ex(1, 1, 1, 1, 1, 3, 1));
        addv(ins(1, 11, 12, 1, 1, 13, 1, 0, 0, 0, 0), ex(1, 1, 0, 0, 0, 0, 0));

        drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK);
        chk_all("reset", ex(1, 1, 0, 0, 0, 0, 0));
        chk("reset stall_cnt", hz.stall_cnt, 32'd0);
        chk("reset flush_cnt", hz.flush_cnt, 32'd0);
        @(negedge CLK);
        #1;
        RSTa = 1'b0;
        model_reset();

        foreach (tbl[i]) step(tbl[i].in, tbl[i].ex, 1'b1, $sformatf("vec%0d", i));

        // Asynchronous reset while a div is holding the pipe
        step(ins(1, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0), ex(1, 1, 0, 0, 0, 0, 0), 1'b1, "mcr0");
        v = ins(1, 14, 13, 1, 1, 15, 1, 0, 0, 0, 0);
        step(v, ex(0, 0, 0, 0, 0, 1, 2), 1'b1, "mcr1");
        drive(v);
        #2;
        chk("busy stall_cnt", hz.stall_cnt, CNT_EN ? m_stall : 32'd0);
        chk("busy flush_cnt", hz.flush_cnt, CNT_EN ? m_flush : 32'd0);
        chk("busy pc_write", 32'(hz.pc_write), 32'd0);
        RSTa = 1'b1;
        #1;
        chk_all("async_rst", ex(1, 1, 0, 0, 0, 0, 0));
        chk("async_rst stall_cnt", hz.stall_cnt, 32'd0);
        chk("async_rst flush_cnt", hz.flush_cnt, 32'd0);
        @(negedge CLK);
        #1;
        RSTa = 1'b0;
        model_reset();
        step(v, ex(1, 1, 0, 0, 0, 0, 0), 1'b1, "post_rst");

        e0 = '0;
        for (int n = 0; n < 3000; n++) begin
            v.vld  = ($urandom_range(0, 7) != 0);
            v.rs1  = RBITS'($urandom_range(0, 4));
            v.rs2  = RBITS'($urandom_range(0, 4));
            v.u1   = ($urandom_range(0, 3) != 0);
            v.u2   = ($urandom_range(0, 2) != 0);
            v.rd   = RBITS'($urandom_range(0, 4));
            v.rw   = ($urandom_range(0, 3) != 0);
            v.mr   = ($urandom_range(0, 2) == 0);
            v.mul  = ($urandom_range(0, 9) == 0);
            v.done = ($urandom_range(0, 3) == 0);
            v.br   = ($urandom_range(0, 11) == 0);
            step(v, e0, 1'b0, $sformatf("rnd%0d", n));
        end
        chk("rnd stall_cnt", hz.stall_cnt, CNT_EN ? m_stall : 32'd0);
        chk("rnd flush_cnt", hz.flush_cnt, CNT_EN ? m_flush : 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
